// File: rtl/serial_nibble_add_pkg.sv
// Shared types and sizing helpers for the serial nibble adder.
package serial_nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width; a single-slice build still needs one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/serial_nibble_adder_nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared across all nibble positions.
module nibble_adder
  import serial_nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c_s;

  // Bitwise full-adder chain.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (x[i] & c_s[i]) | (y[i] & c_s[i]);
    end
    co = c_s[NIBBLE_W];
  end

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder sequenced one nibble per clock through a single ripple slice.
// Optional signed-overflow output enabled by defining SERIAL_NIBBLE_ADD_OVF_EN.
module serial_nibble_adder
  import serial_nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_x,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_y,
  input  logic                    in_c,
  input  logic                    in_valid,
  output logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_s,
  output logic                    out_c,
  output logic                    out_valid,
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
  output logic                    out_v,
`endif
  input  logic                    in_ready
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);
  localparam logic [W-1:0]  NIB_MASK = W'(4'hF);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  out_s_q, out_s_d;
  logic          out_c_q, out_c_d;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
  logic          out_v_q, out_v_d;
`endif

  logic [IW+1:0]       sh_s;
  logic [W-1:0]        x_shift_s, y_shift_s;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c;

  // Nibble position expressed as a bit offset for the shared slice.
  assign sh_s      = {idx_q, 2'b00};
  assign x_shift_s = x_q >> sh_s;
  assign y_shift_s = y_q >> sh_s;

  nibble_adder u_slice (
    .x  (x_shift_s[NIBBLE_W-1:0]),
    .y  (y_shift_s[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_c)
  );

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    out_s_d = out_s_q;
    out_c_d = out_c_q;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
    out_v_d = out_v_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          carry_d = in_c;
          idx_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        out_s_d = (out_s_q & ~(NIB_MASK << sh_s)) | (W'(slice_s) << sh_s);
        carry_d = slice_c;
        if (idx_q == IDX_LAST) begin
          out_c_d = slice_c;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
          // Top slice sum bit is the result sign bit.
          out_v_d = (x_q[W-1] == y_q[W-1]) && (slice_s[NIBBLE_W-1] != x_q[W-1]);
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (in_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      out_s_q <= '0;
      out_c_q <= 1'b0;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
      out_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      out_s_q <= out_s_d;
      out_c_q <= out_c_d;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
      out_v_q <= out_v_d;
`endif
    end
  end

  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_valid = (state_q == DONE);
  assign out_ready = (state_q == IDLE) && !in_rst;
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
  assign out_v     = out_v_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder with NIBBLES=4.
module tb_serial_nibble_adder;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         in_clk = 1'b0;
  logic         in_rst = 1'b1;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         in_c = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready = 1'b0;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_c;
  logic         out_valid;
  logic         out_v;

  int checks = 0;
  int errors = 0;

  always #5 in_clk = ~in_clk;

  serial_nibble_adder #(.NIBBLES(NIBBLES)) dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_c      (in_c),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_c     (out_c),
    .out_valid (out_valid),
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
    .out_v     (out_v),
`endif
    .in_ready  (in_ready)
  );

`ifndef SERIAL_NIBBLE_ADD_OVF_EN
  assign out_v = 1'b0;
`endif

  // Offer one operand set and return cycles from accept until out_valid (-1 on timeout).
  task automatic accept_and_wait(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, output int lat);
    @(negedge in_clk);
    in_x = x; in_y = y; in_c = c; in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge in_clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge in_clk);
    in_ready = 1'b1;
    @(posedge in_clk);
    #1;
    in_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL reset_out_s got %h want 0000", out_s); end
    checks++; if (out_c !== 1'b0) begin errors++; $display("FAIL reset_out_c got %b want 0", out_c); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b want 0", out_v); end
    @(negedge in_clk);
    in_rst = 1'b0;
    #1;
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready got %b want 1", out_ready); end
  endtask

  task automatic test_add();
    logic [W-1:0] xs [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [W-1:0] ys [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0000};
    logic         cs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es [4] = '{16'h5555, 16'h0000, 16'h0000, 16'h0000};
    logic         ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int k = 0; k < 4; k++) begin
      accept_and_wait(xs[k], ys[k], cs[k], lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL add%0d_latency got %0d want 4", k, lat); end
      checks++; if (out_s !== es[k]) begin errors++; $display("FAIL add%0d_sum got %h want %h", k, out_s, es[k]); end
      checks++; if (out_c !== ec[k]) begin errors++; $display("FAIL add%0d_carry got %b want %b", k, out_c, ec[k]); end
      checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL add%0d_ovf got %b want 0", k, out_v); end
      release_result();
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
        errors++; $display("FAIL add%0d_release got valid=%b ready=%b want valid=0 ready=1", k, out_valid, out_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept_and_wait(16'h1234, 16'h4321, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge in_clk);
      in_valid = 1'b1; in_x = 16'hAAAA; in_y = 16'h5555; in_c = 1'b1;
      @(posedge in_clk);
      #1;
      checks++; if (out_s !== 16'h5555 || out_c !== 1'b0 || out_valid !== 1'b1 || out_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got s=%h c=%b valid=%b ready=%b want s=5555 c=0 valid=1 ready=0",
                           k, out_s, out_c, out_valid, out_ready);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", out_ready, out_valid);
    end
    @(posedge in_clk);
    #1;
    checks++; if (out_ready !== 1'b1 || out_s !== 16'h5555) begin
      errors++; $display("FAIL bp_idle got ready=%b s=%h want ready=1 s=5555", out_ready, out_s);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_ready = 1'b1;
    accept_and_wait(16'h00FF, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 4 || out_s !== 16'h0100) begin
      errors++; $display("FAIL b2b_first got lat=%0d s=%h want lat=4 s=0100", lat, out_s);
    end
    @(posedge in_clk);
    #1;
    checks++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_pulse got valid=%b ready=%b want valid=0 ready=1", out_valid, out_ready);
    end
    accept_and_wait(16'h8001, 16'h8001, 1'b1, lat);
    checks++; if (lat !== 4 || out_s !== 16'h0003 || out_c !== 1'b1) begin
      errors++; $display("FAIL b2b_second got lat=%0d s=%h c=%b want lat=4 s=0003 c=1", lat, out_s, out_c);
    end
    @(negedge in_clk);
    in_ready = 1'b0;
  endtask

  task automatic test_reset_mid_add();
    int lat;
    @(negedge in_clk);
    in_x = 16'h1234; in_y = 16'h4321; in_c = 1'b0; in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    in_valid = 1'b0;
    @(posedge in_clk);
    #1;
    in_rst = 1'b1;
    #1;
    checks++; if (out_s !== 16'h0000 || out_c !== 1'b0 || out_valid !== 1'b0 || out_ready !== 1'b0 || out_v !== 1'b0) begin
      errors++; $display("FAIL rst_mid got s=%h c=%b valid=%b ready=%b v=%b want all 0",
                         out_s, out_c, out_valid, out_ready, out_v);
    end
    @(negedge in_clk);
    in_rst = 1'b0;
    #1;
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", out_ready); end
    for (int k = 0; k < 6; k++) begin
      @(posedge in_clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_pulse%0d got %b want 0", k, out_valid); end
    end
    accept_and_wait(16'h0F0F, 16'h00F1, 1'b0, lat);
    checks++; if (lat !== 4 || out_s !== 16'h1000 || out_c !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after got lat=%0d s=%h c=%b want lat=4 s=1000 c=0", lat, out_s, out_c);
    end
    release_result();
  endtask

`ifdef SERIAL_NIBBLE_ADD_OVF_EN
  task automatic test_overflow();
    logic [W-1:0] xs [3] = '{16'h7FFF, 16'h8000, 16'h0001};
    logic [W-1:0] ys [3] = '{16'h0001, 16'h8000, 16'h0001};
    logic [W-1:0] es [3] = '{16'h8000, 16'h0000, 16'h0002};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         ev [3] = '{1'b1, 1'b1, 1'b0};
    int lat;
    for (int k = 0; k < 3; k++) begin
      accept_and_wait(xs[k], ys[k], 1'b0, lat);
      checks++; if (lat !== 4 || out_s !== es[k] || out_c !== ec[k] || out_v !== ev[k]) begin
        errors++; $display("FAIL ovf%0d got lat=%0d s=%h c=%b v=%b want lat=4 s=%h c=%b v=%b",
                           k, lat, out_s, out_c, out_v, es[k], ec[k], ev[k]);
      end
      release_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_add();
`ifdef SERIAL_NIBBLE_ADD_OVF_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
